// File: rtl/contador_pkg.sv
// -----------------------------------------------------------------------------
// contador_pkg
// Shared constants for the modulo-N up/down counter:
//   DEFAULT_WIDTH / DEFAULT_MODULUS / DEFAULT_PRESET_VALUE : default parameters
//   DIR_UP / DIR_DOWN                                      : up_down encodings
//   params_legal()                                         : parameter legality
// -----------------------------------------------------------------------------
package contador_pkg;

    localparam int DEFAULT_WIDTH        = 32'sd4;
    localparam int DEFAULT_MODULUS      = 32'sd13;
    localparam int DEFAULT_PRESET_VALUE = 32'sd12;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    // True when the width/modulus/preset combination describes a usable counter.
    function automatic logic params_legal(input int width, input int modulus, input int preset_value);
        logic ok_v;
        ok_v = (width >= 32'sd1) && (width <= 32'sd30) &&
               (modulus >= 32'sd2) && (modulus <= (32'sd1 << width)) &&
               (preset_value >= 32'sd0) && (preset_value < modulus);
        return ok_v;
    endfunction

endpackage

// File: rtl/contador_mod_n_next.sv
// -----------------------------------------------------------------------------
// contador_mod_n_next
// Combinational next-count logic for the modulo-N counter.
//   counter    : current count value
//   up_down    : direction (DIR_UP / DIR_DOWN)
//   next_count : count after one enabled step, always inside 0..MODULUS-1
//   wrap       : high when that step crosses the modulus boundary
// -----------------------------------------------------------------------------
module contador_mod_n_next
    import contador_pkg::*;
#(
    parameter int WIDTH   = DEFAULT_WIDTH,
    parameter int MODULUS = DEFAULT_MODULUS
) (
    input  logic [WIDTH-1:0] counter,
    input  logic             up_down,
    output logic [WIDTH-1:0] next_count,
    output logic             wrap
);

    // One extra bit so MODULUS = 2**WIDTH is representable and compares cleanly.
    localparam logic [WIDTH:0] LAST_EXT = (WIDTH+1)'(MODULUS - 32'sd1);

    logic [WIDTH:0] count_ext_s;
    logic [WIDTH:0] inc_s;
    logic [WIDTH:0] dec_s;
    logic           unused_carry_s;

    assign count_ext_s = {1'b0, counter};
    assign inc_s       = count_ext_s + {{WIDTH{1'b0}}, 1'b1};
    assign dec_s       = count_ext_s - {{WIDTH{1'b0}}, 1'b1};

    // Carry/borrow never matter: the boundary cases are routed to the wrap branches.
    assign unused_carry_s = inc_s[WIDTH] ^ dec_s[WIDTH];

    // Next count and wrap flag for a single enabled step.
    always_comb begin
        next_count = counter;
        wrap       = 1'b0;
        if (up_down == DIR_UP) begin
            // >= also folds any out-of-range value back to 0.
            if (count_ext_s >= LAST_EXT) begin
                next_count = {WIDTH{1'b0}};
                wrap       = 1'b1;
            end else begin
                next_count = inc_s[WIDTH-1:0];
                wrap       = 1'b0;
            end
        end else begin
            if (count_ext_s == {(WIDTH+1){1'b0}}) begin
                next_count = LAST_EXT[WIDTH-1:0];
                wrap       = 1'b1;
            end else if (count_ext_s > LAST_EXT) begin
                // Out-of-range value is clamped into range rather than decremented.
                next_count = LAST_EXT[WIDTH-1:0];
                wrap       = 1'b0;
            end else begin
                next_count = dec_s[WIDTH-1:0];
                wrap       = 1'b0;
            end
        end
    end

endmodule

// File: rtl/contador_mod_n.sv
// -----------------------------------------------------------------------------
// contador_mod_n
// Modulo-N up/down counter with preset, load and range-checked load.
//   clock      : sole clock, rising edge
//   reset      : synchronous, active-low; clears counter, wrap, load_err
//   preset     : synchronous; loads PRESET_VALUE
//   load       : synchronous; loads load_value (0 plus load_err if out of range)
//   load_value : value for load
//   enable     : count enable
//   up_down    : 1 = up, 0 = down
//   counter    : registered count, always < MODULUS
//   terminal   : combinational; counter at the boundary for the current direction
//   wrap       : registered one-cycle pulse after a wrap
//   load_err   : registered one-cycle pulse after an out-of-range load
// Priority per edge: reset, preset, load, enable, hold.
// -----------------------------------------------------------------------------
module contador_mod_n
    import contador_pkg::*;
#(
    parameter int WIDTH        = DEFAULT_WIDTH,
    parameter int MODULUS      = DEFAULT_MODULUS,
    parameter int PRESET_VALUE = DEFAULT_PRESET_VALUE
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             preset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             enable,
    input  logic             up_down,
    output logic [WIDTH-1:0] counter,
    output logic             terminal,
    output logic             wrap,
    output logic             load_err
);

    generate
        if (!params_legal(WIDTH, MODULUS, PRESET_VALUE)) begin : g_param_error
            $error("contador_mod_n: illegal WIDTH/MODULUS/PRESET_VALUE combination");
        end
    endgenerate

    localparam logic [WIDTH:0]   MOD_EXT    = (WIDTH+1)'(MODULUS);
    localparam logic [WIDTH-1:0] PRESET_CNT = WIDTH'(PRESET_VALUE);

    logic [WIDTH-1:0] counter_r;
    logic             wrap_r;
    logic             load_err_r;
    logic [WIDTH-1:0] next_count_s;
    logic             step_wrap_s;
    logic             load_oor_s;

    assign load_oor_s = ({1'b0, load_value} >= MOD_EXT);

    contador_mod_n_next #(
        .WIDTH   (WIDTH),
        .MODULUS (MODULUS)
    ) u_next (
        .counter    (counter_r),
        .up_down    (up_down),
        .next_count (next_count_s),
        .wrap       (step_wrap_s)
    );

    // terminal is exactly the condition under which an enabled step would wrap,
    // so it tracks counter and up_down only, with no register in between.
    assign terminal = step_wrap_s;
    assign counter  = counter_r;
    assign wrap     = wrap_r;
    assign load_err = load_err_r;

    // Priority mux and state registers; pulses default low on every edge.
    always_ff @(posedge clock) begin
        if (!reset) begin
            counter_r  <= {WIDTH{1'b0}};
            wrap_r     <= 1'b0;
            load_err_r <= 1'b0;
        end else if (preset) begin
            counter_r  <= PRESET_CNT;
            wrap_r     <= 1'b0;
            load_err_r <= 1'b0;
        end else if (load) begin
            wrap_r <= 1'b0;
            if (load_oor_s) begin
                counter_r  <= {WIDTH{1'b0}};
                load_err_r <= 1'b1;
            end else begin
                counter_r  <= load_value;
                load_err_r <= 1'b0;
            end
        end else if (enable) begin
            counter_r  <= next_count_s;
            wrap_r     <= step_wrap_s;
            load_err_r <= 1'b0;
        end else begin
            counter_r  <= counter_r;
            wrap_r     <= 1'b0;
            load_err_r <= 1'b0;
        end
    end

endmodule

// File: tb/tb_contador_mod_n.sv
// -----------------------------------------------------------------------------
// tb_contador_mod_n
// Drives three counters (MODULUS 13, 16, 2) from shared stimulus. A reference
// model pushes expected results into a queue when stimulus is applied; they
// are popped and compared after the clock edge.
// -----------------------------------------------------------------------------
module tb_contador_mod_n;
    import contador_pkg::*;

    typedef struct packed {
        logic [3:0] cnt;
        logic       wrap;
        logic       lerr;
    } exp_t;
    typedef exp_t [2:0] row_t;

    logic            clock = 1'b0;
    logic            reset;
    logic            preset;
    logic            load;
    logic [3:0]      load_value;
    logic            enable;
    logic            up_down;
    logic [2:0][3:0] cnt_s;
    logic [2:0]      term_s;
    logic [2:0]      wrap_s;
    logic [2:0]      lerr_s;

    int checks = 0;
    int errors = 0;

    row_t sb_q[$];
    exp_t st[3];
    int   mods[3]    = '{13, 16, 2};
    int   presets[3] = '{12, 12, 1};

    always #5 clock = ~clock;

    contador_mod_n u_dut (
        .clock(clock), .reset(reset), .preset(preset), .load(load),
        .load_value(load_value), .enable(enable), .up_down(up_down),
        .counter(cnt_s[0]), .terminal(term_s[0]), .wrap(wrap_s[0]), .load_err(lerr_s[0])
    );

    contador_mod_n #(.WIDTH(4), .MODULUS(16), .PRESET_VALUE(12)) u_dut16 (
        .clock(clock), .reset(reset), .preset(preset), .load(load),
        .load_value(load_value), .enable(enable), .up_down(up_down),
        .counter(cnt_s[1]), .terminal(term_s[1]), .wrap(wrap_s[1]), .load_err(lerr_s[1])
    );

    contador_mod_n #(.WIDTH(4), .MODULUS(2), .PRESET_VALUE(1)) u_dut2 (
        .clock(clock), .reset(reset), .preset(preset), .load(load),
        .load_value(load_value), .enable(enable), .up_down(up_down),
        .counter(cnt_s[2]), .terminal(term_s[2]), .wrap(wrap_s[2]), .load_err(lerr_s[2])
    );

    // Single comparison point: counts every check and reports mismatches.
    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference behaviour of one edge for a counter of modulus m.
    function automatic exp_t model_next(input int m, input int pv, input exp_t s,
                                        input logic rst, input logic pre, input logic ld,
                                        input logic [3:0] lv, input logic en, input logic ud);
        exp_t r;
        r.cnt  = s.cnt;
        r.wrap = 1'b0;
        r.lerr = 1'b0;
        if (!rst) begin
            r.cnt = 4'd0;
        end else if (pre) begin
            r.cnt = 4'(pv);
        end else if (ld) begin
            if (int'(lv) >= m) begin
                r.cnt  = 4'd0;
                r.lerr = 1'b1;
            end else begin
                r.cnt = lv;
            end
        end else if (en) begin
            if (ud) begin
                if (int'(s.cnt) == m - 1) begin
                    r.cnt  = 4'd0;
                    r.wrap = 1'b1;
                end else begin
                    r.cnt = s.cnt + 4'd1;
                end
            end else begin
                if (s.cnt == 4'd0) begin
                    r.cnt  = 4'(m - 1);
                    r.wrap = 1'b1;
                end else begin
                    r.cnt = s.cnt - 4'd1;
                end
            end
        end
        return r;
    endfunction

    function automatic logic term_exp(input int m, input logic [3:0] c, input logic ud);
        return ud ? (int'(c) == m - 1) : (c == 4'd0);
    endfunction

    // Apply one edge of stimulus, queue the expectation, then compare outputs.
    task automatic step(input logic rst, input logic pre, input logic ld,
                        input logic [3:0] lv, input logic en, input logic ud);
        row_t e;
        row_t g;
        @(negedge clock);
        reset      = rst;
        preset     = pre;
        load       = ld;
        load_value = lv;
        enable     = en;
        up_down    = ud;
        for (int i = 0; i < 3; i++) begin
            st[i] = model_next(mods[i], presets[i], st[i], rst, pre, ld, lv, en, ud);
            e[i]  = st[i];
        end
        sb_q.push_back(e);
        @(posedge clock);
        #1;
        g = sb_q.pop_front();
        for (int i = 0; i < 3; i++) begin
            check_value($sformatf("m%0d_cnt", mods[i]),  32'(cnt_s[i]),  32'(g[i].cnt));
            check_value($sformatf("m%0d_wrap", mods[i]), 32'(wrap_s[i]), 32'(g[i].wrap));
            check_value($sformatf("m%0d_lerr", mods[i]), 32'(lerr_s[i]), 32'(g[i].lerr));
            check_value($sformatf("m%0d_term", mods[i]), 32'(term_s[i]),
                        32'(term_exp(mods[i], g[i].cnt, up_down)));
        end
    endtask

    initial begin
        logic r_rst;
        logic r_pre;
        logic r_ld;
        logic r_en;
        logic r_ud;
        logic [3:0] r_lv;
        int dn_exp[3];

        reset      = 1'b1;
        preset     = 1'b0;
        load       = 1'b0;
        load_value = 4'd0;
        enable     = 1'b0;
        up_down    = 1'b1;
        for (int i = 0; i < 3; i++) st[i] = '0;

        // Reset with other controls active must still clear everything.
        step(1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
        check_value("rst_cnt", 32'(cnt_s[0]), 32'd0);
        check_value("rst_wrap", 32'(wrap_s[0]), 32'd0);
        check_value("rst_lerr", 32'(lerr_s[0]), 32'd0);

        // Up count through a full cycle of modulus 13.
        for (int i = 0; i < 14; i++) begin
            step(1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
            check_value("up_seq", 32'(cnt_s[0]), 32'((i + 1) % 13));
            check_value("up_wrap", 32'(wrap_s[0]), (i == 12) ? 32'd1 : 32'd0);
            check_value("up_term", 32'(term_s[0]), (i == 11) ? 32'd1 : 32'd0);
        end

        // Back to 0, then flip direction with no edge: terminal follows at once.
        step(1'b1, 1'b0, 1'b1, 4'd0, 1'b0, 1'b1);
        check_value("zero_up_term", 32'(term_s[0]), 32'd0);
        up_down = 1'b0;
        #1;
        check_value("dir_term", 32'(term_s[0]), 32'd1);

        // Down count across the 0 boundary.
        dn_exp = '{12, 11, 10};
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
            check_value("dn_seq", 32'(cnt_s[0]), 32'(dn_exp[i]));
            check_value("dn_wrap", 32'(wrap_s[0]), (i == 0) ? 32'd1 : 32'd0);
        end

        // Preset beats load; then an out-of-range load pulses load_err once.
        step(1'b1, 1'b0, 1'b1, 4'd2, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b1, 4'd5, 1'b1, 1'b1);
        check_value("preset_cnt", 32'(cnt_s[0]), 32'd12);
        check_value("preset_lerr", 32'(lerr_s[0]), 32'd0);
        step(1'b1, 1'b0, 1'b1, 4'd14, 1'b0, 1'b1);
        check_value("oor_cnt", 32'(cnt_s[0]), 32'd0);
        check_value("oor_lerr", 32'(lerr_s[0]), 32'd1);
        check_value("oor_cnt16", 32'(cnt_s[1]), 32'd14);
        step(1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
        check_value("oor_lerr_clr", 32'(lerr_s[0]), 32'd0);

        // Reset overrides preset mid-count; counting resumes from 0.
        step(1'b1, 1'b0, 1'b1, 4'd6, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
        check_value("pre_rst_cnt", 32'(cnt_s[0]), 32'd7);
        step(1'b0, 1'b1, 1'b0, 4'd0, 1'b1, 1'b1);
        check_value("mid_rst_cnt", 32'(cnt_s[0]), 32'd0);
        check_value("mid_rst_wrap", 32'(wrap_s[0]), 32'd0);
        step(1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
        check_value("resume1", 32'(cnt_s[0]), 32'd1);
        step(1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
        check_value("resume2", 32'(cnt_s[0]), 32'd2);

        // Full-range modulus wraps 15->0; modulus 2 toggles.
        step(1'b1, 1'b0, 1'b1, 4'd15, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
        check_value("m16_wrap", 32'(wrap_s[1]), 32'd1);
        check_value("m16_cnt", 32'(cnt_s[1]), 32'd0);
        step(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
            check_value("m2_toggle", 32'(cnt_s[2]), 32'((i + 1) % 2));
        end

        // Random mix of all controls.
        for (int n = 0; n < 400; n++) begin
            r_rst = ($urandom_range(0, 19) != 0);
            r_pre = ($urandom_range(0, 11) == 0);
            r_ld  = ($urandom_range(0, 7) == 0);
            r_lv  = 4'($urandom_range(0, 15));
            r_en  = ($urandom_range(0, 3) != 0);
            r_ud  = ($urandom_range(0, 2) != 0);
            step(r_rst, r_pre, r_ld, r_lv, r_en, r_ud);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
